// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch_unit signal bundle: imem req/gnt/rvalid, redirect, decode valid/ready
//
// Signals (direction as seen from fetch_unit, i.e. the master modport):
//   redirect_i, redirect_pc_i           in  : taken branch/jump (PCSrc) and its target
//   imem_req_o, imem_addr_o             out : word fetch request and address
//   imem_gnt_i                          in  : request accepted this cycle
//   imem_rvalid_i, imem_rdata_i         in  : response beat and instruction word
//   instr_valid_o, instr_o, pc_o,
//   pc_plus4_o                          out : FIFO head presented to decode
//   instr_ready_i                       in  : decode consumes the head this cycle
//   misalign_o                          out : sticky misaligned-redirect flag (FETCH_ALIGN_CHECK_EN only)
interface fetch_unit_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        instr_ready_i;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign_o;
`endif

    modport master (
        input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o
`ifdef FETCH_ALIGN_CHECK_EN
        , output misalign_o
`endif
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o
`ifdef FETCH_ALIGN_CHECK_EN
        , input misalign_o
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch: PC owner, single-outstanding imem requests, instruction FIFO
//
// Parameters: RESET_PC (first fetch address), DEPTH (FIFO entries, 2 or 4).
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : fetch_unit_if.master (imem handshake, redirect, decode valid/ready)
// Optional feature macro: FETCH_ALIGN_CHECK_EN - a redirect to a non-word-aligned target
// raises the sticky misalign_o flag and parks the unit in HALT. Without it the low target
// bits are zeroed and fetch continues.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    fetch_unit_if.master bus
);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    // HALT is only reachable when the alignment check is built in.
    typedef enum logic [2:0] { REQ, WAIT, IDLE, DROP, HALT } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [PW:0]   count_q, count_d, post_count;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          push, pop, flush, head_valid;
    logic [31:0]   target, head_pc;

    // Masking rather than slicing keeps every target bit in use in both builds.
    assign target     = bus.redirect_pc_i & 32'hFFFF_FFFC;
    assign head_valid = (count_q != '0);
    // A redirect flushes the FIFO, so a pop in that cycle is meaningless.
    assign pop        = head_valid && bus.instr_ready_i && !bus.redirect_i;
    assign post_count = count_q + (PW+1)'(1) - (PW+1)'(pop);

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;
    logic misaligned;
    assign misaligned     = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
    assign bus.misalign_o = misalign_q;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            REQ: begin
                if (bus.imem_gnt_i) begin
                    req_pc_d = fetch_pc_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid_i) begin
                    push       = 1'b1;
                    fetch_pc_d = req_pc_q + 32'd4;
                    state_d    = (post_count < FULL) ? REQ : IDLE;
                end
            end
            IDLE: begin
                if (count_q < FULL) state_d = REQ;
            end
            DROP: begin
                if (bus.imem_rvalid_i) state_d = REQ;
            end
            default: state_d = state_q;
        endcase

        if (bus.redirect_i && state_q != HALT) begin
            push       = 1'b0;
            flush      = 1'b1;
            fetch_pc_d = target;
            case (state_q)
                // A grant in the redirect cycle belongs to the old path; its beat is still owed.
                REQ:       state_d = bus.imem_gnt_i ? DROP : REQ;
                WAIT, DROP: state_d = bus.imem_rvalid_i ? REQ : DROP;
                IDLE:      state_d = REQ;
                default:   state_d = state_q;
            endcase
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned) state_d = HALT;
`endif
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush)             count_d = '0;
        else if (push && !pop) count_d = count_q + (PW+1)'(1);
        else if (!push && pop) count_d = count_q - (PW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned) misalign_q <= 1'b1;
`endif
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q]    <= req_pc_q;
            instr_mem[wr_ptr_q] <= bus.imem_rdata_i;
        end
    end

    assign head_pc           = head_valid ? pc_mem[rd_ptr_q] : 32'h0000_0000;
    assign bus.imem_req_o    = rst_ni && (state_q == REQ);
    assign bus.imem_addr_o   = fetch_pc_q;
    assign bus.instr_valid_o = head_valid;
    assign bus.instr_o       = head_valid ? instr_mem[rd_ptr_q] : NOP;
    assign bus.pc_o          = head_pc;
    assign bus.pc_plus4_o    = head_pc + 32'd4;
endmodule
